// File: rtl/mxn_logic_pkg.sv
// Opcode encodings and FSM state type shared by the mXn logic controllers.
// Pure declarations: no latency, no backpressure.
// Used by any module that issues or decodes mXn logic commands.
package mxn_logic_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_LAST = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/nbit_logic_lane.sv
// Combinational WIDTH-bit bitwise lane selected by a 3-bit opcode.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module nbit_logic_lane
    import mxn_logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mxn_logic_sequencer.sv
// Steps one shared logic lane across SETS operand slices, one slice per cycle.
// Latency: result valid SETS edges after accept (1 edge path for an illegal opcode).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional MXN_SEQ_ZERO_MASK_EN adds zero_mask.
module mxn_logic_sequencer
    import mxn_logic_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SETS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [SETS*WIDTH-1:0] in1_packed,
    input  logic [SETS*WIDTH-1:0] in2_packed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SETS*WIDTH-1:0] out_packed,
    output logic                  out_err
`ifdef MXN_SEQ_ZERO_MASK_EN
    ,
    output logic [SETS-1:0]       zero_mask
`endif
);

    localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int N     = SETS * WIDTH;

    if (SETS < 1 || WIDTH < 1) begin : g_param_check
        $error("mxn_logic_sequencer: WIDTH and SETS must both be >= 1");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] set_idx_q, set_idx_d;
    logic [2:0]       op_q, op_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     res_q, res_d;
    logic             err_q, err_d;
    logic [SETS-1:0]  zm_q, zm_d;

    logic [WIDTH-1:0] lane_a, lane_b, lane_y;

    nbit_logic_lane #(.WIDTH(WIDTH)) u_lane (
        .op (op_q),
        .a  (lane_a),
        .b  (lane_b),
        .y  (lane_y)
    );

    // Slice select is a plain mux on set_idx; upper codes never occur.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < SETS; i++) begin
            if (set_idx_q == IDX_W'(i)) begin
                lane_a = a_q[i*WIDTH +: WIDTH];
                lane_b = b_q[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        set_idx_d = set_idx_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        err_d     = err_q;
        zm_d      = zm_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = in_op;
                    a_d       = in1_packed;
                    b_d       = in2_packed;
                    res_d     = '0;
                    zm_d      = '0;
                    set_idx_d = '0;
                    if (op_is_legal(in_op)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                for (int i = 0; i < SETS; i++) begin
                    if (set_idx_q == IDX_W'(i)) begin
                        res_d[i*WIDTH +: WIDTH] = lane_y;
                        zm_d[i]                 = ~|lane_y;
                    end
                end
                if (set_idx_q == IDX_W'(SETS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    set_idx_d = set_idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            set_idx_q <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            zm_q      <= '0;
        end else begin
            state_q   <= state_d;
            set_idx_q <= set_idx_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            err_q     <= err_d;
            zm_q      <= zm_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_packed = res_q;
    assign out_err    = err_q;

`ifdef MXN_SEQ_ZERO_MASK_EN
    assign zero_mask = zm_q;
`else
    logic unused_zm;
    assign unused_zm = ^zm_q;
`endif

endmodule

// File: tb/tb_mxn_logic_sequencer.sv
// Directed and random commands against a whole-vector bitwise reference model.
module tb_mxn_logic_sequencer;

    localparam int WIDTH = 4;
    localparam int SETS  = 2;
    localparam int N     = SETS * WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [N-1:0]  in1_packed;
    logic [N-1:0]  in2_packed;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_packed;
    logic          out_err;
`ifdef MXN_SEQ_ZERO_MASK_EN
    logic [SETS-1:0] zero_mask;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mxn_logic_sequencer #(.WIDTH(WIDTH), .SETS(SETS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in1_packed (in1_packed),
        .in2_packed (in2_packed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packed (out_packed),
        .out_err    (out_err)
`ifdef MXN_SEQ_ZERO_MASK_EN
        ,
        .zero_mask  (zero_mask)
`endif
    );

    // Every op is bitwise, so the whole packed vector is computed in one step.
    function automatic logic [N-1:0] model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic logic [SETS-1:0] model_zm(input logic [2:0] op, input logic [N-1:0] r);
        logic [SETS-1:0] m;
        m = '0;
        if (op != 3'd7)
            for (int i = 0; i < SETS; i++)
                m[i] = (((r >> (i*WIDTH)) & {WIDTH{1'b1}}) == '0);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input int hold, input string tag);
        logic [N-1:0] exp;
        logic [N-1:0] snap;
        int           lat;
        int           n;
        logic         busy_ok;
        logic         stable;
        exp = model(op, a, b);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " ready_wait"}, 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_op      = op;
        in1_packed = a;
        in2_packed = b;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_op      = 3'($urandom);
        in1_packed = N'($urandom);
        in2_packed = N'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        if (op != 3'd7) chk({tag, " latency"}, 32'(lat), 32'(SETS));
        else            chk({tag, " err_latency"}, 32'(lat <= 1), 32'd1);
        chk({tag, " busy_in_ready"}, 32'(busy_ok), 32'd1);
        snap = out_packed;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            in_valid   = 1'b1;
            in_op      = 3'($urandom);
            in1_packed = N'($urandom);
            in2_packed = N'($urandom);
            @(posedge clk); #1;
            if (out_packed !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) chk({tag, " hold_stable"}, 32'(stable), 32'd1);
        chk({tag, " out_packed"}, 32'(out_packed), 32'(exp));
        chk({tag, " out_err"}, 32'(out_err), 32'(op == 3'd7));
`ifdef MXN_SEQ_ZERO_MASK_EN
        chk({tag, " zero_mask"}, 32'(zero_mask), 32'(model_zm(op, exp)));
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " post_err"}, 32'(out_err), 32'd0);
        chk({tag, " post_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic       saw_valid;
        logic [2:0] rop;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = '0;
        in1_packed = '0;
        in2_packed = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_packed", 32'(out_packed), 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
`ifdef MXN_SEQ_ZERO_MASK_EN
        chk("reset zero_mask", 32'(zero_mask), 32'd0);
`endif

        run_cmd(3'd1, 8'hF3, 8'h5A, 0, "and");
        chk("and literal", 32'(model(3'd1, 8'hF3, 8'h5A)), 32'h52);
        run_cmd(3'd0, 8'hA5, 8'hFF, 0, "not");
        run_cmd(3'd6, 8'hF0, 8'hFF, 0, "xnor");
        run_cmd(3'd5, 8'h3C, 8'h0F, 10, "xor_bp");
        run_cmd(3'd7, 8'hFF, 8'hFF, 2, "illegal");
        run_cmd(3'd2, 8'h0F, 8'h00, 0, "or_zm");
        run_cmd(3'd4, 8'h00, 8'h00, 0, "nor");
        run_cmd(3'd3, 8'hFF, 8'hFF, 1, "nand");

        in_valid   = 1'b1;
        in_op      = 3'd2;
        in1_packed = 8'hFF;
        in2_packed = 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun in_ready", 32'(in_ready), 32'd1);
        chk("midrun out_valid", 32'(out_valid), 32'd0);
        chk("midrun out_packed", 32'(out_packed), 32'd0);
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("midrun no_stale", 32'(saw_valid), 32'd0);

        for (int t = 0; t < 25; t++) begin
            rop = 3'($urandom_range(0, 7));
            run_cmd(rop, N'($urandom), N'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
